// File: rtl/common_pkg.sv
// Shared frame-store types and default 640x480@60 VGA timing constants.
package common;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    localparam int BAR_WIDTH = 80;

    // Bar i lights each channel fully when the matching index bit is set.
    function automatic pixel_t bar_colour(input logic [2:0] idx);
        pixel_t p;
        p.r = {8{idx[2]}};
        p.g = {8{idx[1]}};
        p.b = {8{idx[0]}};
        return p;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters, visible/sync windows and the registered end-of-visible-frame pulse.
module vga_timing
    import common::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       visible,
    output logic       h_sync_on,
    output logic       v_sync_on,
    output logic       frame_pulse
);

    localparam int LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(LINE_LEN - 1);
    localparam logic [9:0] V_LAST   = 10'(FRAME_LINES - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            frame_pulse <= 1'b0;
        end else begin
            // Counters at (0, V_VISIBLE): the last visible read is already in the pipeline.
            frame_pulse <= (h_count == '0) && (v_count == V_VIS);
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    always_comb begin
        visible   = (h_count < H_VIS) && (v_count < V_VIS);
        h_sync_on = (h_count >= HS_START) && (h_count < HS_END);
        v_sync_on = (v_count >= VS_START) && (v_count < VS_END);
    end

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer scan-out to a VGA sink with two-stage alignment for the buffer's read latency.
// Optional colour bars are built only when VGA_SCANOUT_TEST_PATTERN_EN is defined.
module vga_scanout
    import common::*;
#(
    parameter int   H_VISIBLE   = H_VISIBLE_DEF,
    parameter int   H_FRONT     = H_FRONT_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BACK      = H_BACK_DEF,
    parameter int   V_VISIBLE   = V_VISIBLE_DEF,
    parameter int   V_FRONT     = V_FRONT_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BACK      = V_BACK_DEF,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] address_a_x,
    output logic [9:0] address_a_y,
    input  pixel_t     data_a,
    output logic       vga_frame_complete,
    input  logic       test_pattern,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       visible;
    logic       h_sync_on;
    logic       v_sync_on;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .h_count     (h_count),
        .v_count     (v_count),
        .visible     (visible),
        .h_sync_on   (h_sync_on),
        .v_sync_on   (v_sync_on),
        .frame_pulse (vga_frame_complete)
    );

    // Blanked cycles read row 0 so the buffer never sees an out-of-range row.
    always_comb begin
        address_a_x = visible ? h_count : '0;
        address_a_y = visible ? v_count : '0;
    end

    logic   vis_s1;
    logic   hs_s1;
    logic   vs_s1;
    pixel_t pix_out;
    pixel_t pix_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vis_s1 <= 1'b0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
        end else begin
            vis_s1 <= visible;
            hs_s1  <= h_sync_on;
            vs_s1  <= v_sync_on;
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [6:0] seg_count;
    logic [2:0] bar_idx;
    logic [2:0] bar_s1;

    // bar_idx tracks the bar under the current h_count; it restarts in every blank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_count <= '0;
            bar_idx   <= '0;
            bar_s1    <= '0;
        end else begin
            bar_s1 <= bar_idx;
            if (!visible) begin
                seg_count <= '0;
                bar_idx   <= '0;
            end else if (seg_count == 7'(BAR_WIDTH - 1)) begin
                seg_count <= '0;
                bar_idx   <= bar_idx + 3'd1;
            end else begin
                seg_count <= seg_count + 7'd1;
            end
        end
    end

    always_comb begin
        pix_next = '0;
        if (vis_s1) begin
            pix_next = test_pattern ? bar_colour(bar_s1) : data_a;
        end
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;

    always_comb begin
        pix_next = '0;
        if (vis_s1) begin
            pix_next = data_a;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_hsync   <= ~SYNC_ACTIVE;
            vga_vsync   <= ~SYNC_ACTIVE;
            vga_blank_n <= 1'b0;
            pix_out     <= '0;
        end else begin
            vga_hsync   <= hs_s1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vga_vsync   <= vs_s1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vga_blank_n <= vis_s1;
            pix_out     <= pix_next;
        end
    end

    assign vga_r = pix_out.r;
    assign vga_g = pix_out.g;
    assign vga_b = pix_out.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full 800-clock lines with a shortened vertical frame, random buffer
// contents and random test_pattern, checked every cycle against a raster-position model.
module tb_vga_scanout;
    import common::*;

    localparam int VV = 10;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int LINE   = 800;
    localparam int LINES  = VV + VF + VS + VB;
    localparam int FRAME  = LINE * LINES;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam bit PATTERN = 1'b1;
`else
    localparam bit PATTERN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] address_a_x;
    logic [9:0] address_a_y;
    pixel_t     data_a;
    logic       vga_frame_complete;
    logic       test_pattern = 1'b0;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_blank_n;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;

    int          total = 0;
    int          bad = 0;
    int          c = 0;
    logic        tp_exp = 1'b0;
    logic [23:0] seed;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    vga_scanout #(
        .V_VISIBLE (VV),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .address_a_x        (address_a_x),
        .address_a_y        (address_a_y),
        .data_a             (data_a),
        .vga_frame_complete (vga_frame_complete),
        .test_pattern       (test_pattern),
        .vga_hsync          (vga_hsync),
        .vga_vsync          (vga_vsync),
        .vga_blank_n        (vga_blank_n),
        .vga_r              (vga_r),
        .vga_g              (vga_g),
        .vga_b              (vga_b)
    );

    function automatic logic [23:0] pix(input logic [9:0] x, input logic [9:0] y);
        return {x[7:0], y[7:0], 8'h5A} ^ seed;
    endfunction

    // Buffer port a: one-cycle registered read.
    always @(posedge clock) data_a <= pixel_t'(pix(address_a_x, address_a_y));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s c=%0d got=%h want=%h", tag, c, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
        check({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        check({tag, "_rgb"}, {8'h0, vga_r, vga_g, vga_b}, 32'd0);
        check({tag, "_fc"}, 32'(vga_frame_complete), 32'd0);
        check({tag, "_addr_x"}, 32'(address_a_x), 32'd0);
        check({tag, "_addr_y"}, 32'(address_a_y), 32'd0);
    endtask

    // Expected outputs at c clocks after release: the sink sees raster position c-2.
    task automatic check_cycle();
        int          k, x, y, xa, ya;
        logic        vis, vis_a, hs_e, vs_e, fc_e;
        logic [2:0]  bar;
        logic [23:0] rgb_e;
        logic [9:0]  ax_e, ay_e;
        hs_e = 1'b1; vs_e = 1'b1; vis = 1'b0; rgb_e = '0;
        if (c >= 2) begin
            k = c - 2;
            x = k % LINE;
            y = (k / LINE) % LINES;
            vis  = (x < 640) && (y < VV);
            hs_e = !((x >= 656) && (x < 752));
            vs_e = !((y >= VV + VF) && (y < VV + VF + VS));
            if (vis) begin
                bar = 3'(x / 80);
                if (PATTERN && tp_exp) rgb_e = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
                else rgb_e = pix(10'(x), 10'(y));
            end
        end
        fc_e = 1'b0;
        if (exp_q.size() > 0 && exp_q[0] == 32'(c)) begin
            fc_e = 1'b1;
            void'(exp_q.pop_front());
        end
        xa = c % LINE;
        ya = (c / LINE) % LINES;
        vis_a = (xa < 640) && (ya < VV);
        ax_e = vis_a ? 10'(xa) : 10'd0;
        ay_e = vis_a ? 10'(ya) : 10'd0;
        check("hsync", 32'(vga_hsync), 32'(hs_e));
        check("vsync", 32'(vga_vsync), 32'(vs_e));
        check("blank_n", 32'(vga_blank_n), 32'(vis));
        check("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, rgb_e});
        check("frame_complete", 32'(vga_frame_complete), 32'(fc_e));
        check("addr_x", 32'(address_a_x), 32'(ax_e));
        check("addr_y", 32'(address_a_y), 32'(ay_e));
    endtask

    // Called at a negedge with reset high; releases it and restarts the model at position 0.
    task automatic release_reset();
        reset = 1'b0;
        c = 0;
        exp_q.delete();
        for (int f = 0; f < 4; f++) exp_q.push_back(32'(f * FRAME + VV * LINE + 1));
        check_cycle();
        test_pattern = 1'($urandom_range(0, 1));
        tp_exp = test_pattern;
    endtask

    task automatic step();
        @(negedge clock);
        c++;
        check_cycle();
        test_pattern = 1'($urandom_range(0, 1));
        tp_exp = test_pattern;
    endtask

    initial begin
        int vs_low, hs_low, hs_fall, fc_count;
        logic hs_prev;
        seed = 24'($urandom);
        vs_low = 0; hs_low = 0; hs_fall = -1; fc_count = 0; hs_prev = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("reset");
        release_reset();

        // Two full frames plus a margin.
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            step();
            if (c >= 2 && c < 2 + FRAME && vga_vsync == 1'b0) vs_low++;
            if (c >= 2 && c < 2 + LINE && vga_hsync == 1'b0) hs_low++;
            if (hs_fall < 0 && hs_prev && !vga_hsync) hs_fall = c;
            hs_prev = vga_hsync;
            if (vga_frame_complete) fc_count++;
        end
        check("vsync_low_cycles", 32'(vs_low), 32'd1600);
        check("hsync_low_cycles", 32'(hs_low), 32'd96);
        check("hsync_first_fall", 32'(hs_fall), 32'd658);
        check("frame_pulses", 32'(fc_count), 32'd2);

        // Mid-frame reset with counters at (300, 5).
        while (c < 2 * FRAME + 5 * LINE + 300) step();
        check("mid_addr_x", 32'(address_a_x), 32'd300);
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("held_reset");
        release_reset();

        fc_count = 0;
        for (int i = 0; i < FRAME + 10; i++) begin
            step();
            if (vga_frame_complete) fc_count++;
        end
        check("frame_pulses_after_reset", 32'(fc_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
